// File: rtl/rf_multiport.sv
// Multi-read, dual-write register file with a sweeping synchronous clear.
// Define RF_MULTIPORT_BYPASS_EN to forward same-cycle write data to matching read ports.
module rf_multiport #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned N_RD    = 2,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [N_RD*DATA_W-1:0]   o_rd_data,
  input  logic [ADDR_W-1:0]        i_wr_addr_a,
  input  logic [DATA_W-1:0]        i_wr_data_a,
  input  logic                     i_wr_en_a,
  input  logic [ADDR_W-1:0]        i_wr_addr_b,
  input  logic [DATA_W-1:0]        i_wr_data_b,
  input  logic                     i_wr_en_b,
  input  logic                     i_clr,
  output logic                     o_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] sweep_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok_a;
  logic              wr_ok_b;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;

  always_comb begin
    wr_ok_a = i_wr_en_a && (state == IDLE) && !i_clr &&
              !(ZERO_R0 && (i_wr_addr_a == '0));
    wr_ok_b = i_wr_en_b && (state == IDLE) && !i_clr &&
              !(ZERO_R0 && (i_wr_addr_b == '0)) &&
              !(i_wr_en_a && (i_wr_addr_a == i_wr_addr_b));
    // A restart request counts as the sweep step for entry 0
    sweep_addr = i_clr ? '0 : clr_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (i_clr) begin
            clr_idx <= ADDR_W'(1);
          end else begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == ADDR_W'(DEPTH - 1)) state <= IDLE;
          end
        end
        IDLE: begin
          if (i_clr) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; contents are only zeroed by the sweep
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[sweep_addr] <= '0;
    end else begin
      if (wr_ok_b) mem[i_wr_addr_b] <= i_wr_data_b;
      if (wr_ok_a) mem[i_wr_addr_a] <= i_wr_data_a;
    end
  end

  always_comb begin
    o_rd_data = '0;
    ra        = '0;
    rd        = '0;
    for (int unsigned k = 0; k < N_RD; k++) begin
      ra = i_rd_addr[k*ADDR_W +: ADDR_W];
      rd = mem[ra];
      if (ZERO_R0 && (ra == '0)) rd = '0;
`ifdef RF_MULTIPORT_BYPASS_EN
      if (wr_ok_a && (ra == i_wr_addr_a))      rd = i_wr_data_a;
      else if (wr_ok_b && (ra == i_wr_addr_b)) rd = i_wr_data_b;
`endif
      if (state == CLEAR) rd = '0;
      o_rd_data[k*DATA_W +: DATA_W] = rd;
    end
  end

  assign o_busy = (state == CLEAR);

endmodule
